// File: rtl/gfx_pkg.sv
// Shared graphics types, widths and colour constants for the pixel pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gfx_pkg;

    localparam int COORD_W = 12;
    localparam int RGB_W   = 24;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    // Rectangle as produced by the edge generator: x in [x1,x2), y in [y1,y2).
    typedef struct packed {
        coord_t x1;
        coord_t x2;
        coord_t y1;
        coord_t y2;
    } rect_t;

    localparam rgb_t BLACK = 24'h00_00_00;
    localparam rgb_t WHITE = 24'hFF_FF_FF;

    // Half-open unsigned span test. A span with lo >= hi is empty, which also
    // covers edges that wrapped around zero (e.g. lo = 4070, hi = 50).
    function automatic logic in_span(input coord_t lo, input coord_t hi, input coord_t p);
        return (lo <= p) && (p < hi);
    endfunction

endpackage : gfx_pkg

// File: rtl/rect_hit_test.sv
// Combinational rectangle hit test: half-open span compare on both axes plus optional outline band.
// Latency: 0 cycles (purely combinational; the caller registers the results).
// Backpressure: none; outputs follow inputs continuously.
//
// Ports:
//   rect       - rectangle edges {x1,x2,y1,y2}, 12-bit unsigned each
//   x, y       - pixel position under test
//   hx, hy     - x in [x1,x2) / y in [y1,y2)
//   on_border  - pixel lies within BORDER_W of an edge (tied high when the outline
//                build option RECT_OUTLINE_EN is not defined, giving a solid fill)
module rect_hit_test
    import gfx_pkg::*;
#(
    parameter int BORDER_W = 4
)(
    input  rect_t                rect,
    input  logic [COORD_W-1:0]   x,
    input  logic [COORD_W-1:0]   y,
    output logic                 hx,
    output logic                 hy,
    output logic                 on_border
);

    // Outline thickness must fit the 8-bit range the 13-bit sums are sized for.
    if (BORDER_W < 1 || BORDER_W > 255) begin : g_bad_border_w
        $error("rect_hit_test: BORDER_W must be in 1..255");
    end

    assign hx = in_span(rect.x1, rect.x2, x);
    assign hy = in_span(rect.y1, rect.y2, y);

`ifdef RECT_OUTLINE_EN
    localparam logic [COORD_W:0] BW = (COORD_W+1)'(BORDER_W);

    logic [COORD_W:0] x_e;
    logic [COORD_W:0] y_e;
    logic [COORD_W:0] x1_e;
    logic [COORD_W:0] x2_e;
    logic [COORD_W:0] y1_e;
    logic [COORD_W:0] y2_e;

    assign x_e  = {1'b0, x};
    assign y_e  = {1'b0, y};
    assign x1_e = {1'b0, rect.x1};
    assign x2_e = {1'b0, rect.x2};
    assign y1_e = {1'b0, rect.y1};
    assign y2_e = {1'b0, rect.y2};

    // "x >= x2 - BW" is rewritten as "x + BW >= x2" so nothing is subtracted:
    // every term is a sum of two 12-bit-ish values in 13 bits and cannot wrap.
    // A rectangle thinner than 2*BW in a dimension is entirely inside the band,
    // so it renders fully filled without any special case.
    assign on_border = (x_e < x1_e + BW) || (x_e + BW >= x2_e) ||
                       (y_e < y1_e + BW) || (y_e + BW >= y2_e);
`else
    assign on_border = 1'b1;
`endif

endmodule : rect_hit_test

// File: rtl/rect_pixel_renderer.sv
// Renders one rectangle into the video stream: per-frame shadowed edges, registered RGB and aligned syncs.
// Latency: 2 pixel strobes from i_x/i_y/i_de/i_hs/i_vs to all o_* outputs.
// Backpressure: none; every stage holds while i_pix_stb is low and advances together on a strobe.
//
// Ports:
//   i_clk, i_rst            - clock, synchronous active-high reset
//   i_pix_stb               - pixel strobe, pipeline advance enable
//   i_x, i_y, i_de, i_hs, i_vs, i_frame - raster position/timing from the timing generator
//   i_x1, i_x2, i_y1, i_y2  - live rectangle edges, sampled only on a strobed i_frame
//   o_rgb, o_de, o_hs, o_vs - pixel colour and delayed timing for the TMDS encoder
//   o_in_rect               - delayed hit flag for debug/overlay
// Build option: RECT_OUTLINE_EN draws only a BORDER_W-wide outline instead of a solid fill.
module rect_pixel_renderer
    import gfx_pkg::*;
#(
    parameter rgb_t FG_COLOR = WHITE,
    parameter rgb_t BG_COLOR = 24'h00_00_40,
    parameter int   BORDER_W = 4
)(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_pix_stb,
    input  logic [COORD_W-1:0]   i_x,
    input  logic [COORD_W-1:0]   i_y,
    input  logic                 i_de,
    input  logic                 i_hs,
    input  logic                 i_vs,
    input  logic                 i_frame,
    input  logic [COORD_W-1:0]   i_x1,
    input  logic [COORD_W-1:0]   i_x2,
    input  logic [COORD_W-1:0]   i_y1,
    input  logic [COORD_W-1:0]   i_y2,
    output logic [RGB_W-1:0]     o_rgb,
    output logic                 o_de,
    output logic                 o_hs,
    output logic                 o_vs,
    output logic                 o_in_rect
);

    // Edges used for the whole frame. Reset value is all-zero, i.e. x1 == x2,
    // an empty rectangle, so nothing is drawn until the first frame strobe.
    rect_t shadow;

    logic  hx0;
    logic  hy0;
    logic  bd0;

    logic  hx1;
    logic  hy1;
    logic  bd1;
    logic  de1;
    logic  hs1;
    logic  vs1;

    logic  hit;

    // Shadow latch. i_frame arrives on the first blanking pixel, so the pixel
    // being compared in that same cycle is blank and may still use old edges.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow <= '0;
        end else if (i_pix_stb && i_frame) begin
            shadow <= '{x1: i_x1, x2: i_x2, y1: i_y1, y2: i_y2};
        end
    end

    rect_hit_test #(
        .BORDER_W (BORDER_W)
    ) u_hit (
        .rect      (shadow),
        .x         (i_x),
        .y         (i_y),
        .hx        (hx0),
        .hy        (hy0),
        .on_border (bd0)
    );

    // Stage 1: registered compare results alongside the raw timing bits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hx1 <= 1'b0;
            hy1 <= 1'b0;
            bd1 <= 1'b0;
            de1 <= 1'b0;
            hs1 <= 1'b0;
            vs1 <= 1'b0;
        end else if (i_pix_stb) begin
            hx1 <= hx0;
            hy1 <= hy0;
            bd1 <= bd0;
            de1 <= i_de;
            hs1 <= i_hs;
            vs1 <= i_vs;
        end
    end

    // Blanking pixels never count as hits, so o_in_rect stays clean for overlays.
    assign hit = hx1 && hy1 && bd1 && de1;

    // Stage 2: colour select and timing, all registered on the same strobe so
    // colour and syncs leave the block aligned.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rgb     <= BLACK;
            o_de      <= 1'b0;
            o_hs      <= 1'b0;
            o_vs      <= 1'b0;
            o_in_rect <= 1'b0;
        end else if (i_pix_stb) begin
            o_rgb     <= !de1 ? BLACK : (hit ? FG_COLOR : BG_COLOR);
            o_de      <= de1;
            o_hs      <= hs1;
            o_vs      <= vs1;
            o_in_rect <= hit;
        end
    end

endmodule : rect_pixel_renderer

// File: tb/tb_rect_pixel_renderer.sv
// Self-checking bench for rect_pixel_renderer with a reference model of the rendering rules.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_rect_pixel_renderer;

    localparam logic [23:0] FG = 24'hFF_FF_FF;
    localparam logic [23:0] BG = 24'h00_00_40;
    localparam int          BW = 4;

    typedef struct packed {
        logic [23:0] rgb;
        logic        de;
        logic        hs;
        logic        vs;
        logic        inr;
    } out_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_pix_stb = 1'b0;
    logic [11:0] i_x = '0;
    logic [11:0] i_y = '0;
    logic        i_de = 1'b0;
    logic        i_hs = 1'b0;
    logic        i_vs = 1'b0;
    logic        i_frame = 1'b0;
    logic [11:0] i_x1 = '0;
    logic [11:0] i_x2 = '0;
    logic [11:0] i_y1 = '0;
    logic [11:0] i_y2 = '0;
    logic [23:0] o_rgb;
    logic        o_de;
    logic        o_hs;
    logic        o_vs;
    logic        o_in_rect;

    out_t obs;
    assign obs = '{rgb: o_rgb, de: o_de, hs: o_hs, vs: o_vs, inr: o_in_rect};

    always #5 i_clk = ~i_clk;

    rect_pixel_renderer #(
        .FG_COLOR (FG),
        .BG_COLOR (BG),
        .BORDER_W (BW)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_pix_stb (i_pix_stb),
        .i_x       (i_x),
        .i_y       (i_y),
        .i_de      (i_de),
        .i_hs      (i_hs),
        .i_vs      (i_vs),
        .i_frame   (i_frame),
        .i_x1      (i_x1),
        .i_x2      (i_x2),
        .i_y1      (i_y1),
        .i_y2      (i_y2),
        .o_rgb     (o_rgb),
        .o_de      (o_de),
        .o_hs      (o_hs),
        .o_vs      (o_vs),
        .o_in_rect (o_in_rect)
    );

    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: edges in force for the current frame, and the
    // outputs still travelling through the two-strobe delay.
    int   mx1 = 0, mx2 = 0, my1 = 0, my2 = 0;
    out_t exp_q[$];
    out_t cur_exp = '0;

    function automatic out_t model(input int x, input int y, input bit de, input bit hs, input bit vs);
        out_t r;
        bit   hit;
        hit = de && (x >= mx1) && (x < mx2) && (y >= my1) && (y < my2);
`ifdef RECT_OUTLINE_EN
        hit = hit && ((x < mx1 + BW) || (x >= mx2 - BW) || (y < my1 + BW) || (y >= my2 - BW));
`endif
        r.rgb = !de ? 24'h0 : (hit ? FG : BG);
        r.de  = de;
        r.hs  = hs;
        r.vs  = vs;
        r.inr = hit;
        return r;
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, then
    // return 1 time unit after the edge so callers sample away from it.
    task automatic step(input bit stb, input int x, input int y, input bit de,
                        input bit hs, input bit vs, input bit frame, input bit rst);
        i_pix_stb = stb;
        i_x       = 12'(x);
        i_y       = 12'(y);
        i_de      = de;
        i_hs      = hs;
        i_vs      = vs;
        i_frame   = frame;
        i_rst     = rst;
        @(posedge i_clk);
        if (rst) begin
            exp_q.delete();
            exp_q.push_back('0);
            cur_exp = '0;
            mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        end else if (stb) begin
            exp_q.push_back(model(int'(i_x), int'(i_y), de, hs, vs));
            cur_exp = exp_q.pop_front();
            if (frame) begin
                mx1 = int'(i_x1); mx2 = int'(i_x2); my1 = int'(i_y1); my2 = int'(i_y2);
            end
        end
        #1;
    endtask

    task automatic set_edges(input int x1, input int x2, input int y1, input int y2);
        i_x1 = 12'(x1); i_x2 = 12'(x2); i_y1 = 12'(y1); i_y2 = 12'(y2);
    endtask

    // Push one pixel plus a blank filler so the pixel reaches the outputs.
    task automatic render(input int x, input int y, input bit de);
        step(1'b1, x, y, de, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame_strobe();
        step(1'b1, 640, 480, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 320, 240, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            n_cmp++;
            if (obs !== out_t'('0)) begin
                n_bad++;
                $display("FAIL reset_state[%0d]: got %h want 0", k, obs);
            end
        end
        // Empty shadow after reset: active pixels are background.
        render(5, 5, 1'b1);
        n_cmp++;
        if (o_rgb !== BG || o_in_rect !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_empty_rect: got rgb=%h in=%b want rgb=%h in=0", o_rgb, o_in_rect, BG);
        end
    endtask

    task automatic test_basic();
        int px[5] = '{320, 370, 270, 369, 270};
        int py[5] = '{240, 240, 203, 276, 277};
        logic [23:0] want[5];
        want[0] = FG; want[1] = BG; want[2] = FG; want[3] = FG; want[4] = BG;
`ifdef RECT_OUTLINE_EN
        want[0] = BG;
`endif
        set_edges(270, 370, 203, 277);
        frame_strobe();
        for (int k = 0; k < 5; k++) begin
            render(px[k], py[k], 1'b1);
            n_cmp++;
            if (o_rgb !== want[k] || obs !== cur_exp) begin
                n_bad++;
                $display("FAIL basic(%0d,%0d): got rgb=%h out=%h want rgb=%h out=%h",
                         px[k], py[k], o_rgb, obs, want[k], cur_exp);
            end
        end
    endtask

    task automatic test_midframe_change();
        logic [23:0] w_in;
        w_in = FG;
`ifdef RECT_OUTLINE_EN
        w_in = BG;
`endif
        set_edges(0, 100, 0, 75);
        render(50, 50, 1'b1);
        n_cmp++;
        if (o_rgb !== BG) begin
            n_bad++;
            $display("FAIL midframe_old_rect(50,50): got %h want %h", o_rgb, BG);
        end
        render(320, 240, 1'b1);
        n_cmp++;
        if (o_rgb !== w_in) begin
            n_bad++;
            $display("FAIL midframe_old_rect(320,240): got %h want %h", o_rgb, w_in);
        end
        frame_strobe();
        render(50, 50, 1'b1);
        n_cmp++;
        if (o_rgb !== w_in) begin
            n_bad++;
            $display("FAIL newframe_rect(50,50): got %h want %h", o_rgb, w_in);
        end
        render(320, 240, 1'b1);
        n_cmp++;
        if (o_rgb !== BG) begin
            n_bad++;
            $display("FAIL newframe_rect(320,240): got %h want %h", o_rgb, BG);
        end
    endtask

    task automatic test_strobe_hold();
        bit hsv = 1'b0;
        bit hs_sent[$];
        int xs;
        for (int k = 0; k < 32; k++) begin
            bit stb;
            stb = (k % 4) == 3;
            if (stb) hsv = ~hsv;
            xs = (hs_sent.size() % 2 == 0) ? 100 : 99;
            if (!stb) xs = $urandom_range(0, 4095);
            step(stb, xs, 50, 1'b1, stb ? hsv : bit'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
            if (stb) hs_sent.push_back(hsv);
            n_cmp++;
            if (obs !== cur_exp) begin
                n_bad++;
                $display("FAIL strobe_hold[%0d]: got %h want %h", k, obs, cur_exp);
            end
            if (stb && hs_sent.size() >= 2) begin
                n_cmp++;
                if (o_hs !== hs_sent[hs_sent.size()-2]) begin
                    n_bad++;
                    $display("FAIL hs_delay[%0d]: got %b want %b", k, o_hs, hs_sent[hs_sent.size()-2]);
                end
            end
        end
    endtask

    task automatic test_de_low();
        render(50, 50, 1'b0);
        n_cmp++;
        if (o_rgb !== 24'h0 || o_in_rect !== 1'b0 || o_de !== 1'b0) begin
            n_bad++;
            $display("FAIL de_low: got rgb=%h in=%b de=%b want 0/0/0", o_rgb, o_in_rect, o_de);
        end
    endtask

    task automatic test_wrap();
        bit saw = 1'b0;
        set_edges(4070, 50, 203, 277);
        frame_strobe();
        for (int k = 0; k < 200; k++) begin
            int x;
            case ($urandom_range(0, 2))
                0: x = $urandom_range(0, 60);
                1: x = $urandom_range(4060, 4095);
                default: x = $urandom_range(0, 4095);
            endcase
            step($urandom_range(0, 3) != 0, x, $urandom_range(190, 290), 1'b1,
                 1'b0, 1'b0, 1'b0, 1'b0);
            if (o_in_rect === 1'b1) saw = 1'b1;
            n_cmp++;
            if (obs !== cur_exp) begin
                n_bad++;
                $display("FAIL wrap_model[%0d]: got %h want %h", k, obs, cur_exp);
            end
        end
        n_cmp++;
        if (saw !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_in_rect: got asserted want never");
        end
    endtask

    task automatic test_outline_points();
        int px[4] = '{272, 320, 366, 365};
        logic [23:0] want[4];
`ifdef RECT_OUTLINE_EN
        want[0] = FG; want[1] = BG; want[2] = FG; want[3] = BG;
`else
        want[0] = FG; want[1] = FG; want[2] = FG; want[3] = FG;
`endif
        set_edges(270, 370, 203, 277);
        frame_strobe();
        for (int k = 0; k < 4; k++) begin
            render(px[k], 240, 1'b1);
            n_cmp++;
            if (o_rgb !== want[k]) begin
                n_bad++;
                $display("FAIL outline(%0d,240): got %h want %h", px[k], o_rgb, want[k]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        render(272, 240, 1'b1);
        step(1'b1, 300, 240, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 300, 240, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (obs !== out_t'('0)) begin
            n_bad++;
            $display("FAIL reset_midframe: got %h want 0", obs);
        end
        render(320, 240, 1'b1);
        n_cmp++;
        if (o_rgb !== BG || o_in_rect !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset_empty: got rgb=%h in=%b want %h/0", o_rgb, o_in_rect, BG);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            int x1, y1;
            x1 = $urandom_range(0, 700);
            y1 = $urandom_range(0, 500);
            set_edges(x1, x1 + $urandom_range(0, 60) - 10, y1, y1 + $urandom_range(0, 40) - 6);
            frame_strobe();
            for (int j = 0; j < 300; j++) begin
                int x, y;
                bit rst, frm;
                if ($urandom_range(0, 7) == 0)
                    set_edges($urandom_range(0, 4095), $urandom_range(0, 4095),
                              $urandom_range(0, 4095), $urandom_range(0, 4095));
                x = ($urandom_range(0, 1) == 0) ? mx1 : mx2;
                x = x + $urandom_range(0, 10) - 5;
                if ($urandom_range(0, 3) == 0) x = $urandom_range(0, 799);
                y = (($urandom_range(0, 1) == 0) ? my1 : my2) + $urandom_range(0, 10) - 5;
                if ($urandom_range(0, 1) == 0) y = $urandom_range(my1, my1 + 30);
                rst = (f == 2) && (j == 150);
                frm = ($urandom_range(0, 63) == 0);
                step($urandom_range(0, 3) != 0, x, y, $urandom_range(0, 7) != 0,
                     $urandom_range(0, 1), $urandom_range(0, 1), frm, rst);
                n_cmp++;
                if (obs !== cur_exp) begin
                    n_bad++;
                    $display("FAIL random[f%0d j%0d]: got %h want %h", f, j, obs, cur_exp);
                end
            end
        end
    endtask

    initial begin
        exp_q.push_back('0);
        test_reset();
        test_basic();
        test_midframe_change();
        test_strobe_hold();
        test_de_low();
        test_wrap();
        test_outline_points();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rect_pixel_renderer

// File: doc/rect_pixel_renderer.md
Name: rect_pixel_renderer

Overview:
- Downstream consumer of the rectangle edge generator (x1/x2/y1/y2 edges, 12-bit).
- Compares the current raster position from the display timing generator against a per-frame latched copy of the edges.
- Emits registered 24-bit RGB plus delayed sync/DE, aligned for the HDMI/TMDS encoder.
- Edges are shadow-latched only at frame start, so a moving rectangle never tears mid-frame.

Parameters:
- FG_COLOR, 24'hFF_FF_FF, RGB888 inside the rectangle.
- BG_COLOR, 24'h00_00_40, RGB888 inside the active area but outside the rectangle.
- BORDER_W, 4, outline thickness in pixels; used only with RECT_OUTLINE_EN; legal range 1..255.

Ports:
- i_clk  in  1  base clock.
- i_rst  in  1  synchronous, active-high reset.
- i_pix_stb  in  1  pixel strobe; the pipeline advances only when high.
- i_x  in  12  current horizontal pixel position.
- i_y  in  12  current vertical pixel position.
- i_de  in  1  active-video enable.
- i_hs  in  1  hsync, passed through.
- i_vs  in  1  vsync, passed through.
- i_frame  in  1  one-strobe pulse marking start of frame (first blanking pixel).
- i_x1  in  12  rectangle left edge.
- i_x2  in  12  rectangle right edge.
- i_y1  in  12  rectangle top edge.
- i_y2  in  12  rectangle bottom edge.
- o_rgb  out  24  pixel colour {R,G,B}.
- o_de  out  1  delayed DE.
- o_hs  out  1  delayed hsync.
- o_vs  out  1  delayed vsync.
- o_in_rect  out  1  delayed hit flag, for debug/overlay.

Behaviour:
- Reset, synchronous and active-high, clears all of the following:
  - o_rgb = 0, o_de = o_hs = o_vs = o_in_rect = 0.
  - Shadow edges = 0, which makes an empty rectangle (x1 == x2).
  - Pipeline registers = 0.
- Shadow latch: on a cycle with i_pix_stb && i_frame, capture i_x1..i_y2 into the shadow registers. At all other times the shadow holds.
- Simultaneous i_rst with i_frame: reset wins.
- Pipeline, advancing only on i_pix_stb (all stages hold when i_pix_stb is low):
  - Stage 1 registers: hx = (sx1 <= i_x) && (i_x < sx2); hy = (sy1 <= i_y) && (i_y < sy2). Bounds are half-open.
  - Stage 1 also registers i_de/i_hs/i_vs.
  - Stage 2 registers hit = hx && hy && de1.
  - Stage 2 output colour: o_rgb = !de1 ? 24'h0 : (hit ? FG_COLOR : BG_COLOR).
  - Stage 2 registers o_de/o_hs/o_vs from the stage-1 copies.
- Latency: exactly 2 pixel strobes from i_x/i_y/syncs to o_*. Syncs and colour stay aligned.
- All comparisons are unsigned 12-bit.
- Degenerate rectangle handling:
  - If sx1 >= sx2 or sy1 >= sy2, nothing is drawn.
  - This covers wrapped edges, e.g. a centre near 0 giving x1 = 4070, x2 = 50.
  - Whole frame renders BG_COLOR; no partial or wrap-around drawing.
- Reset mid-frame: outputs go to 0 on the next clock. Rendering resumes with an empty rectangle until the next i_frame strobe.
- The edge inputs may change at any time; only values present on the i_frame strobe are used.

Optional Feature:
- Macro: RECT_OUTLINE_EN.
- When defined, hit additionally requires the pixel to lie within BORDER_W of any edge: (i_x < sx1+BORDER_W) || (i_x >= sx2-BORDER_W) || (i_y < sy1+BORDER_W) || (i_y >= sy2-BORDER_W).
  - This term is computed in stage 1 using 13-bit sums to avoid overflow.
  - Interior pixels render BG_COLOR.
  - If the rectangle is narrower than 2*BORDER_W in a dimension, it is fully filled.
- When not defined: solid fill and no border logic. Latency is unchanged in both builds.

Decomposition:
- Shared package gfx_pkg holds: COORD_W = 12, RGB_W = 24, typedef coord_t [11:0], typedef rgb_t [23:0], struct rect_t {x1, x2, y1, y2}, and colour constants BLACK / WHITE.
- One natural sub-module: rect_hit_test. It is the stage-1 combinational compare (half-open span test plus the optional border test) and is reusable for further sprites.

Test Plan:
- Reset, then 640x480 raster with edges 270/370/203/277 latched at i_frame:
  - pixel (320,240) -> FG_COLOR.
  - pixel (370,240) -> BG_COLOR (right edge exclusive).
  - pixel (270,203) -> FG_COLOR.
- Edges changed to 0/100/0/75 mid-frame -> current frame still shows old rectangle; the change takes effect only from the next i_frame strobe.
- i_x = 100, i_hs toggled with i_pix_stb every 4th clock -> o_hs and the matching o_rgb change exactly 2 strobes later; outputs hold between strobes.
- i_de = 0 inside the rectangle -> o_rgb = 0, o_in_rect = 0.
- Wrapped edges x1 = 4070, x2 = 50 -> full frame BG_COLOR, o_in_rect never asserts.
- RECT_OUTLINE_EN with BORDER_W = 4, rect 270/370/203/277:
  - (272,240) -> FG_COLOR; (320,240) -> BG_COLOR; (366,240) -> FG_COLOR.
  - i_rst asserted mid-frame -> all outputs 0 next clock.
